// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter in front of a single SRAM controller port.
// m0 is instruction fetch, m1 is data. The grant is combinational, so a request
// reaches the controller in the same cycle it is raised. A small FIFO of grant
// IDs remembers which port issued each accepted request, so in-order responses
// are routed back to the right requester.
module sram_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ROUND_ROBIN     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic                    m0_we,
  input  logic [DATA_WIDTH/8-1:0] m0_wbe,
  input  logic                    m0_req_valid,
  output logic                    m0_req_ready,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  output logic                    m0_resp_valid,
  input  logic                    m0_resp_ready,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic                    m1_we,
  input  logic [DATA_WIDTH/8-1:0] m1_wbe,
  input  logic                    m1_req_valid,
  output logic                    m1_req_ready,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    m1_resp_valid,
  input  logic                    m1_resp_ready,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  output logic                    s_we,
  output logic [DATA_WIDTH/8-1:0] s_wbe,
  output logic                    s_req_valid,
  input  logic                    s_req_ready,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  input  logic                    s_resp_valid,
  output logic                    s_resp_ready
);

  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [PTR_WIDTH-1:0] LAST_PTR   = PTR_WIDTH'(MAX_OUTSTANDING - 1);

  // Request-side state: lock holds the granted port steady while the
  // controller stalls; lastGrant drives the round-robin tie break.
  logic                       r_lock;
  logic                       r_lockSel;
  logic                       r_lastGrant;

  // Grant-ID FIFO: one bit per outstanding request (0 = m0, 1 = m1).
  logic [MAX_OUTSTANDING-1:0] r_fifo;
  logic [PTR_WIDTH-1:0]       r_wptr;
  logic [PTR_WIDTH-1:0]       r_rptr;
  logic [CNT_WIDTH-1:0]       r_count;

  logic                       w_full;
  logic                       w_empty;
  logic                       w_sel;
  logic                       w_head;
  logic                       w_push;
  logic                       w_pop;

  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rptr];

  // Grant selection: a locked grant wins, then a lone requester, then the tie break.
  always_comb begin
    w_sel = 1'b0;
    if (r_lock) begin
      w_sel = r_lockSel;
    end else if (m0_req_valid && !m1_req_valid) begin
      w_sel = 1'b0;
    end else if (m1_req_valid && !m0_req_valid) begin
      w_sel = 1'b1;
    end else if (ROUND_ROBIN != 0) begin
      w_sel = ~r_lastGrant;
    end else begin
      w_sel = 1'b1;
    end
  end

  // Valid/ready outputs are forced low while reset is asserted.
  assign s_req_valid  = rst_n && !w_full && (r_lock || m0_req_valid || m1_req_valid);
  assign m0_req_ready = s_req_valid && s_req_ready && (w_sel == 1'b0);
  assign m1_req_ready = s_req_valid && s_req_ready && (w_sel == 1'b1);

  assign s_addr  = w_sel ? m1_addr  : m0_addr;
  assign s_wdata = w_sel ? m1_wdata : m0_wdata;
  assign s_we    = w_sel ? m1_we    : m0_we;
  assign s_wbe   = w_sel ? m1_wbe   : m0_wbe;

  assign m0_rdata      = s_rdata;
  assign m1_rdata      = s_rdata;
  assign m0_resp_valid = rst_n && s_resp_valid && !w_empty && (w_head == 1'b0);
  assign m1_resp_valid = rst_n && s_resp_valid && !w_empty && (w_head == 1'b1);
  assign s_resp_ready  = rst_n && !w_empty && (w_head ? m1_resp_ready : m0_resp_ready);

  assign w_push = s_req_valid && s_req_ready;
  assign w_pop  = s_resp_valid && s_resp_ready;

  // Lock the grant while the controller stalls; release and record it on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock      <= 1'b0;
      r_lockSel   <= 1'b0;
      r_lastGrant <= 1'b1;
    end else if (w_push) begin
      r_lock      <= 1'b0;
      r_lastGrant <= w_sel;
    end else if (s_req_valid && !s_req_ready) begin
      r_lock      <= 1'b1;
      r_lockSel   <= w_sel;
    end
  end

  // Write side of the grant-ID FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo <= '0;
      r_wptr <= '0;
    end else if (w_push) begin
      r_fifo[r_wptr] <= w_sel;
      r_wptr         <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
    end
  end

  // Read side of the grant-ID FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr <= '0;
    end else if (w_pop) begin
      r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A response with nothing outstanding means the controller broke protocol.
  a_respWhileEmpty: assert property (@(posedge clk) disable iff (!rst_n)
    !(s_resp_valid && w_empty));

  // Full already masks s_req_valid, so this guards the construction itself.
  a_noOverflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && w_full));

  // Pop is gated by s_resp_ready, which already requires a non-empty FIFO.
  a_noUnderflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_pop && w_empty));

endmodule
